regfile_port_ctrl: RTL and testbench

Write-port arbiter and read sequencer for the 32x32 register file. Two writeback sources (execute result, load result) share the register file's single write port through a round-robin valid/ready arbiter. One two-operand read port is sequenced with a fixed 1-cycle latency, and results are bypassed so a read always returns the newest accepted value. The block sits between the pipeline writeback/decode stages and the register file.

---
 rtl/regfile_port_ctrl_pkg.sv | 14 +
 rtl/regfile_port_ctrl_if.sv | 56 +++++
 rtl/regfile_port_ctrl_rr_arb2.sv | 41 ++++
 rtl/regfile_port_ctrl.sv | 137 +++++++++++++
 tb/tb_regfile_port_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_port_ctrl_pkg.sv
// Shared types and defaults for the register-file port controller.
// Imported by the interface, the arbiter and the top level.
package regfile_ctrl_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int X0         = 0;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Writeback, read-request and register-file signals of the port controller.
// The pipeline/register-file side uses master, the controller uses slave.
interface regfile_port_ctrl_if
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_reg1;
    logic [ADDR_W-1:0] rd_reg2;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    logic              rf_write;
    logic [ADDR_W-1:0] rf_writeReg;
    logic [DATA_W-1:0] rf_writeData;
    logic [ADDR_W-1:0] rf_readReg1;
    logic [ADDR_W-1:0] rf_readReg2;
    logic [DATA_W-1:0] rf_readData1;
    logic [DATA_W-1:0] rf_readData2;

    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        output rd_req, rd_reg1, rd_reg2,
        output rf_readData1, rf_readData2,
        input  a_ready, b_ready,
        input  rd_valid, rd_data1, rd_data2,
        input  rf_write, rf_writeReg, rf_writeData,
        input  rf_readReg1, rf_readReg2
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        input  rd_req, rd_reg1, rd_reg2,
        input  rf_readData1, rf_readData2,
        output a_ready, b_ready,
        output rd_valid, rd_data1, rd_data2,
        output rf_write, rf_writeReg, rf_writeData,
        output rf_readReg1, rf_readReg2
    );

endinterface

// File: rtl/regfile_port_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational grants, registered pointer.
// The pointer always moves to the requester that was not just served.
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_valid_a,
    input  logic i_valid_b,
    output logic o_grant_a,
    output logic o_grant_b
);

    req_e r_ptr;

    // Grants are suppressed while rst is high so nothing transfers in reset.
    always_comb begin
        o_grant_a = 1'b0;
        o_grant_b = 1'b0;
        if (!rst) begin
            if (i_valid_a && i_valid_b) begin
                o_grant_a = (r_ptr == REQ_A);
                o_grant_b = (r_ptr == REQ_B);
            end else begin
                o_grant_a = i_valid_a;
                o_grant_b = i_valid_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= REQ_A;
        end else if (o_grant_a) begin
            r_ptr <= REQ_B;
        end else if (o_grant_b) begin
            r_ptr <= REQ_A;
        end
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Write-port arbiter and bypassed read sequencer for the 32x32 register file.
// One write and one two-operand read per cycle; reads see the newest accepted write.
module regfile_port_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
)(
    input  logic               clk,
    input  logic               rst,
    regfile_port_ctrl_if.slave bus
);

    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_acc;
    logic              w_acc_live;
    logic [ADDR_W-1:0] w_acc_reg;
    logic [DATA_W-1:0] w_acc_data;
    logic              w_ws_commit;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;

    logic              r_ws_vld_p1;
    logic [ADDR_W-1:0] r_ws_reg_p1;
    logic [DATA_W-1:0] r_ws_data_p1;

    logic              r_rd_vld_p1;
    logic [ADDR_W-1:0] r_rd_idx1_p1;
    logic [ADDR_W-1:0] r_rd_idx2_p1;
    logic              r_old_vld_p1;
    logic [ADDR_W-1:0] r_old_reg_p1;
    logic [DATA_W-1:0] r_old_data_p1;
    logic              r_new_vld_p1;
    logic [ADDR_W-1:0] r_new_reg_p1;
    logic [DATA_W-1:0] r_new_data_p1;
    logic [DATA_W-1:0] r_rd_hold1;
    logic [DATA_W-1:0] r_rd_hold2;

    function automatic logic [DATA_W-1:0] sel_operand(
        input logic [ADDR_W-1:0] idx,
        input logic              new_vld,
        input logic [ADDR_W-1:0] new_reg,
        input logic [DATA_W-1:0] new_data,
        input logic              old_vld,
        input logic [ADDR_W-1:0] old_reg,
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] rf_data
    );
        if (idx == ADDR_W'(X0))                return '0;
        else if (new_vld && new_reg == idx)    return new_data;
        else if (old_vld && old_reg == idx)    return old_data;
        else                                   return rf_data;
    endfunction

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_valid_a (bus.a_valid),
        .i_valid_b (bus.b_valid),
        .o_grant_a (w_gnt_a),
        .o_grant_b (w_gnt_b)
    );

    assign bus.a_ready = w_gnt_a;
    assign bus.b_ready = w_gnt_b;

    assign w_acc      = w_gnt_a | w_gnt_b;
    assign w_acc_reg  = w_gnt_b ? bus.b_reg  : bus.a_reg;
    assign w_acc_data = w_gnt_b ? bus.b_data : bus.a_data;
    assign w_acc_live = w_acc && (w_acc_reg != ADDR_W'(X0));

    // ---- p0 -> p1: write stage ----
    always_ff @(posedge clk) begin
        if (rst) r_ws_vld_p1 <= 1'b0;
        else     r_ws_vld_p1 <= w_acc;
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_ws_reg_p1  <= w_acc_reg;
            r_ws_data_p1 <= w_acc_data;
        end
    end

    // x0 writes occupy the stage but never drive the register file.
    assign w_ws_commit      = r_ws_vld_p1 && (r_ws_reg_p1 != ADDR_W'(X0));
    assign bus.rf_write     = w_ws_commit;
    assign bus.rf_writeReg  = r_ws_reg_p1;
    assign bus.rf_writeData = r_ws_data_p1;

    assign bus.rf_readReg1 = bus.rd_reg1;
    assign bus.rf_readReg2 = bus.rd_reg2;

    // ---- p0 -> p1: read capture with both bypass candidates ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld_p1  <= 1'b0;
            r_old_vld_p1 <= 1'b0;
            r_new_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1  <= bus.rd_req;
            r_old_vld_p1 <= w_ws_commit;
            r_new_vld_p1 <= w_acc_live;
        end
    end

    always_ff @(posedge clk) begin
        r_rd_idx1_p1  <= bus.rd_reg1;
        r_rd_idx2_p1  <= bus.rd_reg2;
        r_old_reg_p1  <= r_ws_reg_p1;
        r_old_data_p1 <= r_ws_data_p1;
        r_new_reg_p1  <= w_acc_reg;
        r_new_data_p1 <= w_acc_data;
    end

    // ---- p1: operand select; rf_readData arrives from the file's own register ----
    assign w_rd_data1 = sel_operand(r_rd_idx1_p1, r_new_vld_p1, r_new_reg_p1, r_new_data_p1,
                                    r_old_vld_p1, r_old_reg_p1, r_old_data_p1, bus.rf_readData1);
    assign w_rd_data2 = sel_operand(r_rd_idx2_p1, r_new_vld_p1, r_new_reg_p1, r_new_data_p1,
                                    r_old_vld_p1, r_old_reg_p1, r_old_data_p1, bus.rf_readData2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_hold1 <= '0;
            r_rd_hold2 <= '0;
        end else if (r_rd_vld_p1) begin
            r_rd_hold1 <= w_rd_data1;
            r_rd_hold2 <= w_rd_data2;
        end
    end

    assign bus.rd_valid = r_rd_vld_p1;
    assign bus.rd_data1 = r_rd_vld_p1 ? w_rd_data1 : r_rd_hold1;
    assign bus.rd_data2 = r_rd_vld_p1 ? w_rd_data2 : r_rd_hold2;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl: directed cases, then random traffic
// compared against an architectural register model and a behavioural register file.
module tb_regfile_port_ctrl;
    import regfile_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        int            due;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wexp_t;

    typedef struct {
        int            due;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } rexp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_port_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_port_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file: no reset, registered read that returns pre-write contents.
    logic [DW-1:0] mem [32] = '{default: '0};
    always @(posedge clk) begin
        bus.rf_readData1 <= mem[bus.rf_readReg1];
        bus.rf_readData2 <= mem[bus.rf_readReg2];
        if (bus.rf_write) mem[bus.rf_writeReg] <= bus.rf_writeData;
    end

    // Reference: architectural state as seen by the newest accepted write.
    logic [DW-1:0] arch [32] = '{default: '0};
    bit    a_turn = 1'b1;
    wexp_t wq[$];
    rexp_t rq[$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_a(input logic [AW-1:0] r, input logic [DW-1:0] d);
        bus.a_valid = 1'b1; bus.a_reg = r; bus.a_data = d;
    endtask

    task automatic set_b(input logic [AW-1:0] r, input logic [DW-1:0] d);
        bus.b_valid = 1'b1; bus.b_reg = r; bus.b_data = d;
    endtask

    task automatic set_rd(input logic en, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bus.rd_req = en; bus.rd_reg1 = r1; bus.rd_reg2 = r2;
    endtask

    // One clock cycle: predict and check readies, update the model, advance.
    task automatic step();
        bit ga, gb;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        rexp_t re;
        wexp_t we;
        @(negedge clk);
        ga = 1'b0; gb = 1'b0;
        if (!rst) begin
            if (bus.a_valid && bus.b_valid) begin
                ga = a_turn; gb = !a_turn;
            end else begin
                ga = bus.a_valid; gb = bus.b_valid;
            end
        end
        chk("a_ready", bus.a_ready, ga);
        chk("b_ready", bus.b_ready, gb);
        if (rst) begin
            a_turn = 1'b1;
        end else if (ga || gb) begin
            a_turn = gb;
            wr = ga ? bus.a_reg  : bus.b_reg;
            wd = ga ? bus.a_data : bus.b_data;
            if (wr != 0) begin
                arch[wr] = wd;
                we.due = cyc + 1; we.r = wr; we.d = wd;
                wq.push_back(we);
            end
        end
        if (!rst && bus.rd_req) begin
            re.due = cyc + 1;
            re.d1 = arch[bus.rd_reg1];
            re.d2 = arch[bus.rd_reg2];
            rq.push_back(re);
        end
        @(posedge clk);
        #1;
        if (ga) bus.a_valid = 1'b0;
        if (gb) bus.b_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && (bus.a_valid || bus.b_valid); k++) step();
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a read result.
    always @(negedge clk) begin
        if (mon_en) begin
            wexp_t we;
            rexp_t re;
            while (wq.size() > 0 && wq[0].due < cyc) begin
                we = wq.pop_front();
                n_cmp++; n_err++;
                $display("FAIL rf_write_missing: got none, expected reg %0d data %h (cycle %0d)", we.r, we.d, cyc);
            end
            if (wq.size() > 0 && wq[0].due == cyc) begin
                we = wq.pop_front();
                chk("rf_write", bus.rf_write, 1'b1);
                chk("rf_writeReg", bus.rf_writeReg, we.r);
                chk("rf_writeData", bus.rf_writeData, we.d);
            end else begin
                chk("rf_write_idle", bus.rf_write, 1'b0);
            end

            while (rq.size() > 0 && rq[0].due < cyc) begin
                re = rq.pop_front();
                n_cmp++; n_err++;
                $display("FAIL rd_valid_missing: got none, expected %h/%h (cycle %0d)", re.d1, re.d2, cyc);
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                re = rq.pop_front();
                chk("rd_valid", bus.rd_valid, 1'b1);
                chk("rd_data1", bus.rd_data1, re.d1);
                chk("rd_data2", bus.rd_data2, re.d2);
                last1 = re.d1;
                last2 = re.d2;
            end else begin
                chk("rd_valid_idle", bus.rd_valid, 1'b0);
                chk("rd_data1_hold", bus.rd_data1, last1);
                chk("rd_data2_hold", bus.rd_data2, last2);
            end
            if (rst) begin
                last1 = '0;
                last2 = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
        set_rd(1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Contention from reset: expect A, B, A, B.
        for (int i = 0; i < 4; i++) begin
            if (!bus.a_valid) set_a(AW'(10 + i), 32'hA000_0000 + i);
            if (!bus.b_valid) set_b(AW'(20 + i), 32'hB000_0000 + i);
            step();
        end
        drain();

        // Single write.
        set_a(5, 32'h1234);
        step();
        step();

        // x0 write, then read of x0.
        set_b(0, 32'hFFFF_FFFF);
        step();
        set_rd(1'b1, 0, 5);
        step();
        set_rd(1'b0, 0, 0);
        step();

        // Bypass from W_new, W_old, then from the register file.
        set_a(7, 32'hAA);
        set_rd(1'b1, 7, 7);
        step();
        set_rd(1'b1, 7, 0);
        step();
        set_rd(1'b0, 0, 0);
        step();
        set_rd(1'b1, 7, 5);
        step();
        set_rd(1'b0, 0, 0);

        // Dual match: newest write wins.
        set_a(3, 32'h1);
        step();
        set_a(3, 32'h2);
        set_rd(1'b1, 3, 3);
        step();
        set_rd(1'b0, 0, 0);
        step();

        // Reset with both requesters valid and a read pending.
        set_a(12, 32'hC0DE_0001);
        set_b(13, 32'hC0DE_0002);
        set_rd(1'b1, 12, 13);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_rd(1'b0, 0, 0);
        step();
        drain();

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            if (!bus.a_valid && $urandom_range(0, 1) == 1) set_a(AW'($urandom_range(0, 7)), $urandom);
            if (!bus.b_valid && $urandom_range(0, 1) == 1) set_b(AW'($urandom_range(0, 7)), $urandom);
            set_rd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        set_rd(1'b0, 0, 0);
        drain();
        repeat (3) step();

        chk("write_queue_drained", wq.size(), 0);
        chk("read_queue_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
